// File: rtl/mac_pipe_acc.sv
// mac_pipe_acc: two-stage pipelined signed multiply-accumulate / add-sub
// with an internal accumulator, valid/ready handshakes and optional clamp.
module mac_pipe_acc #(
  parameter int W    = 6,
  parameter int ACCW = 12,
  parameter int OUTW = 13,
  parameter bit SAT  = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [W-1:0]    A,
  input  logic signed [W-1:0]    B,
  input  logic signed [ACCW-1:0] ACC,
  input  logic [1:0]             MODE,
  input  logic                   acc_sel,
  input  logic                   acc_clr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [OUTW-1:0] OUT,
  output logic                   ovf
);

  localparam int PW   = 2 * W;
  localparam int MAXW = (PW > ACCW) ? PW : ACCW;
  localparam int SW   = OUTW + 1;

  localparam logic [OUTW-1:0] OMAX = {1'b0, {(OUTW-1){1'b1}}};
  localparam logic [OUTW-1:0] OMIN = {1'b1, {(OUTW-1){1'b0}}};

  if (OUTW < MAXW + 1) begin : g_bad_outw
    $error("mac_pipe_acc: OUTW must be >= max(2*W, ACCW)+1");
  end

  logic              s1_valid_q, s1_valid_d;
  logic [PW-1:0]     prod_q, prod_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic [ACCW-1:0]   xacc_q, xacc_d;
  logic [1:0]        mode_q, mode_d;
  logic              sel_q, sel_d;

  logic              s2_valid_q, s2_valid_d;
  logic [OUTW-1:0]   out_q, out_d;
  logic              ovf_q, ovf_d;
  logic [OUTW-1:0]   acc_reg_q, acc_reg_d;

  logic              adv1, adv2;
  logic [SW-1:0]     op_a, op_x, op_b, op_bx, sum;
  logic [OUTW-1:0]   res;
  logic              res_ovf;

  always_comb begin
    adv2 = s1_valid_q && (!s2_valid_q || out_ready);
    adv1 = in_valid && (!s1_valid_q || adv2);
  end

  assign in_ready  = !s1_valid_q || adv2;
  assign out_valid = s2_valid_q;
  assign OUT       = out_q;
  assign ovf       = ovf_q;

  // Internal accumulator is read here in S2 so chained sel=1 ops need no bubble
  always_comb begin
    op_a = mode_q[1] ? {{(SW-W){a_q[W-1]}}, a_q}
                     : {{(SW-PW){prod_q[PW-1]}}, prod_q};
    op_x = sel_q ? {acc_reg_q[OUTW-1], acc_reg_q}
                 : {{(SW-ACCW){xacc_q[ACCW-1]}}, xacc_q};
    op_b  = mode_q[1] ? {{(SW-W){b_q[W-1]}}, b_q} : op_x;
    op_bx = mode_q[0] ? ~op_b : op_b;
    sum   = op_a + op_bx + {{(SW-1){1'b0}}, mode_q[0]};
    res_ovf = sum[SW-1] ^ sum[SW-2];
    if (res_ovf && SAT) begin
      res = sum[SW-1] ? OMIN : OMAX;
    end else begin
      res = sum[OUTW-1:0];
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    prod_d     = prod_q;
    a_d        = a_q;
    b_d        = b_q;
    xacc_d     = xacc_q;
    mode_d     = mode_q;
    sel_d      = sel_q;
    if (adv1) begin
      s1_valid_d = 1'b1;
      prod_d     = PW'(A) * PW'(B);
      a_d        = A;
      b_d        = B;
      xacc_d     = ACC;
      mode_d     = MODE;
      sel_d      = acc_sel;
    end else if (adv2) begin
      s1_valid_d = 1'b0;
    end

    s2_valid_d = s2_valid_q;
    out_d      = out_q;
    ovf_d      = ovf_q;
    if (adv2) begin
      s2_valid_d = 1'b1;
      out_d      = res;
      ovf_d      = res_ovf;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end

    // Clear wins over the S2 write-back; the S2 result still goes to OUT
    acc_reg_d = acc_reg_q;
    if (acc_clr) begin
      acc_reg_d = '0;
    end else if (adv2) begin
      acc_reg_d = res;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      prod_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      xacc_q     <= '0;
      mode_q     <= '0;
      sel_q      <= 1'b0;
      s2_valid_q <= 1'b0;
      out_q      <= '0;
      ovf_q      <= 1'b0;
      acc_reg_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      prod_q     <= prod_d;
      a_q        <= a_d;
      b_q        <= b_d;
      xacc_q     <= xacc_d;
      mode_q     <= mode_d;
      sel_q      <= sel_d;
      s2_valid_q <= s2_valid_d;
      out_q      <= out_d;
      ovf_q      <= ovf_d;
      acc_reg_q  <= acc_reg_d;
    end
  end

endmodule

// File: tb/tb_mac_pipe_acc.sv
// tb_mac_pipe_acc: vector tables, corner sequences and a randomized
// scoreboard run against a saturating and a wrapping instance.
module tb_mac_pipe_acc;

  localparam int W    = 6;
  localparam int ACCW = 12;
  localparam int OUTW = 13;
  localparam int OMAX = (1 << (OUTW-1)) - 1;
  localparam int OMIN = -(1 << (OUTW-1));
  localparam int MODV = 1 << OUTW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic acc_sel = 1'b0;
  logic acc_clr = 1'b0;
  logic signed [W-1:0]    A = '0;
  logic signed [W-1:0]    B = '0;
  logic signed [ACCW-1:0] ACC = '0;
  logic [1:0]             MODE = '0;

  logic in_ready_s, in_ready_w;
  logic out_valid_s, out_valid_w;
  logic ovf_s, ovf_w;
  logic signed [OUTW-1:0] out_s, out_w;

  mac_pipe_acc #(.W(W), .ACCW(ACCW), .OUTW(OUTW), .SAT(1'b1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .A(A), .B(B), .ACC(ACC), .MODE(MODE), .acc_sel(acc_sel),
    .acc_clr(acc_clr), .out_valid(out_valid_s), .out_ready(out_ready),
    .OUT(out_s), .ovf(ovf_s)
  );

  mac_pipe_acc #(.W(W), .ACCW(ACCW), .OUTW(OUTW), .SAT(1'b0)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
    .A(A), .B(B), .ACC(ACC), .MODE(MODE), .acc_sel(acc_sel),
    .acc_clr(acc_clr), .out_valid(out_valid_w), .out_ready(out_ready),
    .OUT(out_w), .ovf(ovf_w)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         a;
    int         b;
    int         acc;
    logic [1:0] mode;
    bit         sel;
    bit         clr;
    int         es;
    bit         os;
    int         ew;
    bit         ow;
  } vec_t;

  typedef struct {
    int vs;
    bit os;
    int vw;
    bit ow;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];

  int n_chk = 0;
  int n_err = 0;
  int macc_s = 0;
  int macc_w = 0;
  int n_acc = 0;
  int n_con = 0;
  int last_out_s = 0;
  bit last_acc = 0;
  bit hold_pend = 0;
  logic signed [OUTW-1:0] hold_s, hold_w;

  task automatic chk(input string nm, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, then clamp or wrap
  function automatic void calc(input int a, input int b, input int acc,
                               input logic [1:0] m, input bit sel,
                               input int areg, input bit sat,
                               output int r, output bit o);
    int x, f, s, t;
    x = sel ? areg : acc;
    f = m[1] ? a : a * b;
    s = m[1] ? b : x;
    t = m[0] ? f - s : f + s;
    o = (t > OMAX) || (t < OMIN);
    if (!o) r = t;
    else if (sat) r = (t > OMAX) ? OMAX : OMIN;
    else r = (t > OMAX) ? t - MODV : t + MODV;
  endfunction

  function automatic vec_t mk(input logic [1:0] m, input int a, input int b,
                              input int acc, input bit sel, input bit clr,
                              input int es, input bit os,
                              input int ew, input bit ow);
    vec_t v;
    v.mode = m; v.a = a; v.b = b; v.acc = acc; v.sel = sel; v.clr = clr;
    v.es = es; v.os = os; v.ew = ew; v.ow = ow;
    return v;
  endfunction

  task automatic drv(input bit v, input int a, input int b, input int acc,
                     input logic [1:0] m, input bit sel);
    in_valid = v;
    A        = a[W-1:0];
    B        = b[W-1:0];
    ACC      = acc[ACCW-1:0];
    MODE     = m;
    acc_sel  = sel;
  endtask

  // One clock of scoreboard-checked traffic
  task automatic cyc();
    exp_t e;
    last_acc = 0;
    @(negedge clk);
    chk("hs_ready_match", in_ready_w, in_ready_s);
    chk("hs_valid_match", out_valid_w, out_valid_s);
    if (hold_pend) begin
      chk("hold_valid", out_valid_s, 1);
      chk("hold_out_s", out_s, hold_s);
      chk("hold_out_w", out_w, hold_w);
    end
    hold_pend = out_valid_s && !out_ready;
    hold_s = out_s;
    hold_w = out_w;
    if (out_valid_s && out_ready) begin
      n_con++;
      chk("sb_nonempty", sbq.size() > 0, 1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("sb_out_s", out_s, e.vs);
        chk("sb_ovf_s", ovf_s, e.os);
        chk("sb_out_w", out_w, e.vw);
        chk("sb_ovf_w", ovf_w, e.ow);
        last_out_s = int'(out_s);
      end
    end
    if (in_valid && in_ready_s) begin
      calc(int'(A), int'(B), int'(ACC), MODE, acc_sel, macc_s, 1'b1,
           e.vs, e.os);
      calc(int'(A), int'(B), int'(ACC), MODE, acc_sel, macc_w, 1'b0,
           e.vw, e.ow);
      macc_s = e.vs;
      macc_w = e.vw;
      sbq.push_back(e);
      n_acc++;
      last_acc = 1;
    end
    if (acc_clr) begin
      macc_s = 0;
      macc_w = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain_clr();
    in_valid  = 0;
    out_ready = 1;
    repeat (3) cyc();
    acc_clr = 1;
    cyc();
    acc_clr = 0;
  endtask

  // Table vector c is offered in cycle c, its result expected in cycle c+2
  task automatic run_stream();
    int n;
    n = tbl.size();
    out_ready = 1;
    for (int c = 0; c < n + 2; c++) begin
      if (c < n) begin
        drv(1, tbl[c].a, tbl[c].b, tbl[c].acc, tbl[c].mode, tbl[c].sel);
        acc_clr = tbl[c].clr;
      end else begin
        in_valid = 0;
        acc_clr  = 0;
      end
      @(negedge clk);
      chk("st_in_ready", in_ready_s, 1);
      if (c >= 2) begin
        chk("st_valid", out_valid_s, 1);
        chk("st_out_s", out_s, tbl[c-2].es);
        chk("st_ovf_s", ovf_s, tbl[c-2].os);
        chk("st_out_w", out_w, tbl[c-2].ew);
        chk("st_ovf_w", ovf_w, tbl[c-2].ow);
      end else begin
        chk("st_early_valid", out_valid_s, 0);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    acc_clr  = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int t5a[4];
    int t5b[4];
    int idx, con0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid_s, 0);
    chk("rst_out", out_s, 0);
    chk("rst_ovf", ovf_s, 0);
    chk("rst_in_ready", in_ready_s, 1);
    chk("rst_out_w", out_w, 0);

    tbl.delete();
    tbl.push_back(mk(2'b00, -32, -32,     0, 0, 0,  1024, 0,  1024, 0));
    tbl.push_back(mk(2'b01,   5,   3,   100, 0, 0,   -85, 0,   -85, 0));
    tbl.push_back(mk(2'b10, -32,  31,  1234, 0, 0,    -1, 0,    -1, 0));
    tbl.push_back(mk(2'b11, -32,  31, -1234, 0, 0,   -63, 0,   -63, 0));
    tbl.push_back(mk(2'b00,  31, -32, -2048, 0, 0, -3040, 0, -3040, 0));
    tbl.push_back(mk(2'b01, -32, -32, -2048, 0, 0,  3072, 0,  3072, 0));
    tbl.push_back(mk(2'b11,  31, -32,     7, 0, 0,    63, 0,    63, 0));
    tbl.push_back(mk(2'b10,  31,  31,  2047, 0, 0,    62, 0,    62, 0));
    run_stream();

    acc_clr = 1;
    @(posedge clk);
    #1;
    acc_clr = 0;
    tbl.delete();
    tbl.push_back(mk(2'b00, 31, 31, 5, 1, 0,  961, 0,   961, 0));
    tbl.push_back(mk(2'b00, 31, 31, 5, 1, 0, 1922, 0,  1922, 0));
    tbl.push_back(mk(2'b00, 31, 31, 5, 1, 0, 2883, 0,  2883, 0));
    tbl.push_back(mk(2'b00, 31, 31, 5, 1, 0, 3844, 0,  3844, 0));
    tbl.push_back(mk(2'b00, 31, 31, 5, 1, 0, 4095, 1, -3387, 1));
    run_stream();

    tbl.delete();
    tbl.push_back(mk(2'b00, 1, 1, 9, 1, 0, 4095, 1, -3386, 0));
    tbl.push_back(mk(2'b00, 1, 1, 9, 1, 1,    1, 0,     1, 0));
    run_stream();

    drain_clr();
    t5a = '{3, -7, 12, -32};
    t5b = '{4, 9, -5, 31};
    out_ready = 0;
    idx = 0;
    for (int k = 0; k < 6; k++) begin
      if (idx < 4) drv(1, t5a[idx], t5b[idx], 100 * idx, 2'b00, 0);
      else in_valid = 0;
      cyc();
      if (last_acc) idx++;
    end
    chk("stall_accepted", idx, 2);
    chk("stall_in_ready", in_ready_s, 0);
    chk("stall_out_valid", out_valid_s, 1);
    con0 = n_con;
    out_ready = 1;
    for (int k = 0; k < 12; k++) begin
      if (idx < 4) drv(1, t5a[idx], t5b[idx], 100 * idx, 2'b00, 0);
      else in_valid = 0;
      cyc();
      if (last_acc) idx++;
    end
    chk("stall_all_in", idx, 4);
    chk("stall_delivered", n_con - con0, 4);
    chk("stall_sb_empty", sbq.size(), 0);

    out_ready = 1;
    drv(1, 10, 10, 400, 2'b00, 0);
    cyc();
    in_valid = 0;
    repeat (3) cyc();
    chk("pre_rst_acc", last_out_s, 500);
    out_ready = 0;
    drv(1, 3, 4, 5, 2'b00, 0);
    cyc();
    drv(1, -3, 4, 5, 2'b00, 0);
    cyc();
    in_valid = 0;
    chk("pre_rst_full", in_ready_s, 0);
    #2;
    rst = 1;
    #1;
    chk("mid_rst_valid_s", out_valid_s, 0);
    chk("mid_rst_valid_w", out_valid_w, 0);
    chk("mid_rst_out_s", out_s, 0);
    chk("mid_rst_out_w", out_w, 0);
    chk("mid_rst_ovf_s", ovf_s, 0);
    sbq.delete();
    macc_s = 0;
    macc_w = 0;
    hold_pend = 0;
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
    out_ready = 1;
    drv(1, 1, 1, 777, 2'b00, 1);
    cyc();
    in_valid = 0;
    repeat (3) cyc();
    chk("post_rst_acc", last_out_s, 1);
    chk("post_rst_sb", sbq.size(), 0);

    drain_clr();
    for (int i = 0; i < 400; i++) begin
      if (i % 25 == 24) drain_clr();
      drv($urandom_range(0, 3) != 0,
          int'($urandom_range(0, 63)) - 32,
          int'($urandom_range(0, 63)) - 32,
          int'($urandom_range(0, 4095)) - 2048,
          2'($urandom_range(0, 3)),
          $urandom_range(0, 3) != 0);
      out_ready = $urandom_range(0, 3) != 0;
      cyc();
    end
    in_valid  = 0;
    out_ready = 1;
    repeat (3) cyc();
    chk("rand_sb_drained", sbq.size(), 0);
    chk("rand_traffic", n_con > 100, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
